// File: rtl/board_gpio_ctrl.sv
// Board GPIO: debounced switch inputs with sticky IRQs, LED outputs with off/on/PWM/blink modes.
// Define BOARD_GPIO_PWM_EN to build the PWM dimmer; without it mode 10 drives a constant 1.
module board_gpio_ctrl #(
    parameter int NUM_IN          = 5,
    parameter int NUM_OUT         = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_W           = 8,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        sw_in,
    output logic [NUM_IN-1:0]        sw_db,
    output logic [NUM_IN-1:0]        sw_rise,
    output logic [NUM_IN-1:0]        sw_fall,
    input  logic [NUM_IN-1:0]        irq_mask,
    input  logic [NUM_IN-1:0]        irq_clr,
    output logic [NUM_IN-1:0]        irq_pend,
    output logic                     irq,
    input  logic [2*NUM_OUT-1:0]     led_mode,
    input  logic [PWM_W*NUM_OUT-1:0] led_duty,
    output logic [NUM_OUT-1:0]       led_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BL_W = $clog2(BLINK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

    logic [NUM_IN-1:0]  sw_m;
    logic [NUM_IN-1:0]  sw_s;
    logic [NUM_IN-1:0]  sw_db_d;
    logic [DB_W-1:0]    db_cnt [NUM_IN];
    logic [BL_W-1:0]    bl_cnt;
    logic               blink_phase;
    logic [NUM_OUT-1:0] pwm_lvl;
    logic [NUM_OUT-1:0] led_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m    <= '0;
            sw_s    <= '0;
            sw_db   <= '0;
            sw_db_d <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sw_m    <= sw_in;
            sw_s    <= sw_m;
            sw_db_d <= sw_db;
            sw_rise <= sw_db & ~sw_db_d;
            sw_fall <= ~sw_db & sw_db_d;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sw_s[i] == sw_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    sw_db[i]  <= sw_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A new edge beats a concurrent clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend <= '0;
            irq      <= 1'b0;
        end else begin
            irq_pend <= (irq_pend & ~irq_clr) | ((sw_rise | sw_fall) & ~irq_mask);
            irq      <= |irq_pend;
        end
    end

`ifdef BOARD_GPIO_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty_sh [NUM_OUT];

    // Shadows reload only at the period wrap to keep each period glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                duty_sh[k] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    duty_sh[k] <= led_duty[PWM_W*k +: PWM_W];
                end
            end
        end
    end

    always_comb begin
        pwm_lvl = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            pwm_lvl[k] = pwm_cnt < duty_sh[k];
        end
    end
`else
    logic unused_duty;
    assign unused_duty = ^led_duty;
    assign pwm_lvl     = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bl_cnt      <= '0;
            blink_phase <= 1'b0;
        end else if (bl_cnt == BL_LAST) begin
            bl_cnt      <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bl_cnt <= bl_cnt + 1'b1;
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            unique case (led_mode[2*k +: 2])
                2'b00:   led_nxt[k] = 1'b0;
                2'b01:   led_nxt[k] = 1'b1;
                2'b10:   led_nxt[k] = pwm_lvl[k];
                default: led_nxt[k] = blink_phase;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= '0;
        end else begin
            led_out <= led_nxt;
        end
    end

endmodule

// File: doc/board_gpio_ctrl.md
Name: board_gpio_ctrl

Overview:
- Parametrised board GPIO controller, the successor to the fixed 13-bit tri-state GPIO bank on the EBAZ4205 carrier.
- Input side: NUM_IN raw switch inputs are synchronised and debounced, with edge-detect pulses and maskable sticky interrupts.
- Output side: NUM_OUT LED/aux outputs, each with a per-channel mode: off, on, PWM dimming or blink.
- Sits between board pins and the PS GPIO/interrupt fabric in the system top.

Parameters:
- NUM_IN, 5, number of switch inputs (1..32)
- NUM_OUT, 5, number of LED outputs (1..32)
- DEBOUNCE_CYCLES, 500000, stable cycles required before the debounced state changes (>=2)
- PWM_W, 8, PWM counter and duty width
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw_in  in  NUM_IN  raw asynchronous switch pins
- sw_db  out  NUM_IN  debounced switch state
- sw_rise  out  NUM_IN  one-cycle pulse on debounced 0->1
- sw_fall  out  NUM_IN  one-cycle pulse on debounced 1->0
- irq_mask  in  NUM_IN  1 = channel interrupt masked
- irq_clr  in  NUM_IN  per-channel pending clear, level, sampled each cycle
- irq_pend  out  NUM_IN  sticky pending bits
- irq  out  1  OR of irq_pend
- led_mode  in  2*NUM_OUT  per-channel mode, channel k at [2k+1:2k]
- led_duty  in  PWM_W*NUM_OUT  per-channel duty, channel k at [PWM_W*k +: PWM_W]
- led_out  out  NUM_OUT  LED drive

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst is synchronous, active-high.
- Reset values:
  - Synchroniser flops, sw_db, sw_rise, sw_fall, irq_pend, irq, led_out, all counters and blink phase reset to 0.
  - Duty shadow registers reset to 0.
- Synchroniser:
  - 2-flop per input; sw_s is the second flop.
- Debounce (per channel):
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If sw_s == sw_db, the counter clears.
  - Else the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while a mismatch persists, sw_db <= sw_s and the counter clears.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles never changes sw_db.
  - Total latency from a stable raw change to sw_db is 2+DEBOUNCE_CYCLES cycles.
- Edges:
  - sw_db_d is sw_db delayed one cycle.
  - sw_rise = sw_db & ~sw_db_d; sw_fall = ~sw_db & sw_db_d, both registered.
  - The pulse appears one cycle after the sw_db transition and lasts exactly 1 cycle.
- Interrupts (per channel):
  - Set when (sw_rise|sw_fall) & ~irq_mask.
  - Cleared by irq_clr.
  - Simultaneous set and clear: set wins.
  - Masking does not clear an already-pending bit.
  - irq is the registered OR of irq_pend, 1 cycle after irq_pend.
- PWM:
  - One shared free-running counter pwm_cnt of PWM_W bits, wraps 2^PWM_W-1 -> 0.
  - Per-channel duty shadow loads led_duty only in the cycle pwm_cnt == 2^PWM_W-1, so duty changes are glitch-free at period boundaries.
  - PWM level = (pwm_cnt < duty_shadow).
  - duty 0 gives constant low; duty 2^PWM_W-1 gives high for all but 1 cycle per period.
- Blink:
  - Shared prescaler counts 0..BLINK_DIV-1.
  - At terminal count, blink_phase toggles and the prescaler clears.
  - All blink-mode channels are phase-aligned.
- Modes (led_mode per channel):
  - 00: led_out = 0.
  - 01: led_out = 1.
  - 10: led_out = PWM level.
  - 11: led_out = blink_phase.
- led_out is registered; a mode change is visible 1 cycle after led_mode changes.
- Reset mid-operation:
  - All state returns to reset values in the next cycle.
  - Any in-flight debounce count is discarded.

Optional Feature:
- Macro: BOARD_GPIO_PWM_EN.
- Defined:
  - PWM counter and duty shadows are implemented.
  - Mode 10 behaves as specified.
- Undefined:
  - No PWM counter or shadows are synthesised.
  - led_duty is ignored.
  - Mode 10 behaves identically to mode 01 (constant 1).

Test Plan (DEBOUNCE_CYCLES=4, PWM_W=4, BLINK_DIV=8, BOARD_GPIO_PWM_EN defined unless noted):
- Debounce: sw_in[0] 0->1 held 20 cycles -> sw_db[0]=1 exactly 6 cycles after the change; sw_rise[0] high for 1 cycle, 1 cycle later.
- Glitch reject: sw_in[1] high for 3 cycles then low -> sw_db[1], sw_rise[1] and irq_pend[1] stay 0.
- Interrupts:
  - Masked fall on ch2 -> irq_pend[2]=0.
  - Unmasked rise on ch0 -> irq_pend[0]=1, irq=1 one cycle later.
  - irq_clr[0] asserted in the same cycle as a new edge set -> irq_pend[0] stays 1.
- PWM:
  - mode 10, duty 4 -> led_out high 4 of every 16 cycles.
  - Duty changed to 12 mid-period -> old duty holds until wrap, then 12 of 16.
  - duty 0 -> always 0.
- Blink/modes:
  - mode 11 -> led_out toggles every 8 cycles, all blink channels aligned.
  - mode 00/01 -> constant 0/1 one cycle after the write.
  - Without BOARD_GPIO_PWM_EN, mode 10 -> constant 1.
- Reset: assert rst mid-debounce and during blink -> all outputs 0 next cycle; debounce restarts from full count after rst release.
